// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for EX: shift-add multiply (MUL_STEP bits/cycle),
// restoring radix-2 divide, shared sign-fix / accumulate cycle, {HI,LO} result.
module mdu_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_zero_o
);

    localparam int N  = WIDTH / MUL_STEP;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(N - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    if (WIDTH % MUL_STEP != 0) begin : g_step_check
        $error("mdu_iter: WIDTH must be a multiple of MUL_STEP");
    end

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d, state_nxt;
    logic [2:0]           op_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   a_q;      // shifted multiplicand
    logic [WIDTH-1:0]     b_q;      // multiplier (shifted) / divisor magnitude
    logic [2*WIDTH-1:0]   p_q;      // product, or {remainder, quotient} for divide
    logic                 neg_q;
    logic                 rneg_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q, ready_q, dz_q;
    logic [2*WIDTH-1:0]   result_q;

    logic                 sgn_d, is_div_d;
    logic [WIDTH-1:0]     mag1_d, mag2_d;
    logic [2*WIDTH-1:0]   p_mul_d, p_div_d, fix_d, prod_d;
    logic [WIDTH:0]       rem_sh_d, rem_new_d;
    logic                 ge_d;

    // Operand decode: signed ops have op_i[0]==0, divides are ops 6 and 7.
    always_comb begin
        sgn_d    = ~op_i[0];
        is_div_d = (op_i[2:1] == 2'b11);
        mag1_d   = (sgn_d && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2_d   = (sgn_d && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    // One multiply step and one restoring-divide step.
    always_comb begin
        p_mul_d = p_q;
        for (int j = 0; j < MUL_STEP; j++) begin
            p_mul_d = p_mul_d + (b_q[j] ? (a_q << j) : {(2*WIDTH){1'b0}});
        end
        rem_sh_d  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        ge_d      = (rem_sh_d >= {1'b0, b_q});
        rem_new_d = ge_d ? (rem_sh_d - {1'b0, b_q}) : rem_sh_d;
        p_div_d   = {rem_new_d[WIDTH-1:0], p_q[WIDTH-2:0], ge_d};
    end

    // Sign fix and accumulate, producing the final {HI,LO}.
    always_comb begin
        prod_d = neg_q ? -p_q : p_q;
        case (op_q[2:1])
            2'b01:   fix_d = acc_q + prod_d;
            2'b10:   fix_d = acc_q - prod_d;
            2'b11:   fix_d = {(rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH]),
                              (neg_q  ? -p_q[WIDTH-1:0]       : p_q[WIDTH-1:0])};
            default: fix_d = prod_d;
        endcase
    end

    // Next-state logic; annul_i overrides everything but rst.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (is_div_d) begin
                        state_nxt = (opdata2_i == {WIDTH{1'b0}}) ? S_DONE : S_DIV;
                    end else begin
                        state_nxt = S_MUL;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL:   state_nxt = (cnt_q == MUL_LAST) ? S_FIX : S_MUL;
            S_DIV:   state_nxt = (cnt_q == DIV_LAST) ? S_FIX : S_DIV;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = start_i ? S_DONE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        state_d = annul_i ? S_IDLE : state_nxt;
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
            ready_q <= (state_d == S_DONE);
            if (state_d == S_DONE && state_q == S_IDLE) begin
                dz_q     <= 1'b1;
                result_q <= {(2*WIDTH){1'b0}};
            end else if (state_d == S_DONE && state_q == S_FIX) begin
                dz_q     <= 1'b0;
                result_q <= fix_d;
            end else begin
                dz_q     <= (state_d == S_DONE) ? dz_q : 1'b0;
                result_q <= result_q;
            end
        end
    end

    // Datapath registers: operands latched in IDLE, then iterated.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 3'd0;
            acc_q  <= {(2*WIDTH){1'b0}};
            a_q    <= {(2*WIDTH){1'b0}};
            b_q    <= {WIDTH{1'b0}};
            p_q    <= {(2*WIDTH){1'b0}};
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            cnt_q  <= {CW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    op_q   <= op_i;
                    acc_q  <= acc_i;
                    a_q    <= {{WIDTH{1'b0}}, mag1_d};
                    b_q    <= mag2_d;
                    p_q    <= is_div_d ? {{WIDTH{1'b0}}, mag1_d} : {(2*WIDTH){1'b0}};
                    neg_q  <= sgn_d & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    rneg_q <= sgn_d & opdata1_i[WIDTH-1];
                    cnt_q  <= {CW{1'b0}};
                end
                S_MUL: begin
                    p_q   <= p_mul_d;
                    a_q   <= a_q << MUL_STEP;
                    b_q   <= b_q >> MUL_STEP;
                    cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
                S_DIV: begin
                    p_q   <= p_div_d;
                    cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
                default: begin
                    p_q <= p_q;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign ready_o    = ready_q;
    assign result_o   = result_q;
    assign div_zero_o = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus random ops against an
// arithmetic reference model.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] acc_i;
    logic        annul_i;
    logic        busy_o, ready_o, div_zero_o;
    logic [63:0] result_o;

    int checks = 0;
    int errors = 0;

    mdu_iter #(.WIDTH(32), .MUL_STEP(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .acc_i(acc_i),
        .annul_i(annul_i), .busy_o(busy_o), .ready_o(ready_o),
        .result_o(result_o), .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;

    // Reference: returns {div_zero, result} from plain arithmetic.
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        logic [63:0] prod;
        int sa, sb;
        if (op < 3'd6) begin
            if (op[0]) prod = {32'd0, a} * {32'd0, b};
            else       prod = longint'($signed(a)) * longint'($signed(b));
            case (op[2:1])
                2'd1:    return {1'b0, acc + prod};
                2'd2:    return {1'b0, acc - prod};
                default: return {1'b0, prod};
            endcase
        end
        if (b == 32'd0) return {1'b1, 64'd0};
        if (op[0]) return {1'b0, a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, check latency/result/flags, optionally hold start, then release.
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] acc, input int hold);
        logic [64:0] exp;
        int cyc, lat;
        logic both;
        exp = model(op, a, b, acc);
        lat = (op >= 3'd6) ? ((b == 32'd0) ? 1 : 34) : 10;
        @(negedge clk);
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; acc_i = acc;
        @(posedge clk); #1;
        cyc = 1;
        both = 1'b0;
        op_i = 3'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
        acc_i = {$urandom, $urandom};
        while (!ready_o && cyc < 100) begin
            both |= busy_o & ready_o;
            @(posedge clk); #1;
            cyc++;
        end
        both |= busy_o & ready_o;
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " result"}, result_o, exp[63:0]);
        chk({tag, " div_zero"}, 64'(div_zero_o), 64'(exp[64]));
        chk({tag, " busy&ready"}, 64'(both), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold ready"}, 64'(ready_o), 64'd1);
            chk({tag, " hold result"}, result_o, exp[63:0]);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, " ready drop"}, 64'(ready_o), 64'd0);
        chk({tag, " result kept"}, result_o, exp[63:0]);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1; start_i = 1'b0; op_i = 3'd0; opdata1_i = 32'd0; opdata2_i = 32'd0;
        acc_i = 64'd0; annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        chk("reset dz", 64'(div_zero_o), 64'd0);
        @(negedge clk); rst = 1'b0;

        run("MULT", 3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, 0);
        chk("MULT literal", result_o, 64'hFFFF_FFFF_FFFF_FFFA);
        run("MULTU", 3'd1, 32'hFFFF_FFFE, 32'd3, 64'd0, 0);
        chk("MULTU literal", result_o, 64'h0000_0002_FFFF_FFFA);
        run("DIVU", 3'd7, 32'd100, 32'd7, 64'd0, 0);
        chk("DIVU literal", result_o, 64'h0000_0002_0000_000E);
        run("DIV neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 64'd0, 0);
        chk("DIV neg literal", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
        run("DIV ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 0);
        chk("DIV ovf literal", result_o, 64'h0000_0000_8000_0000);
        run("DIV0", 3'd6, 32'd1234, 32'd0, 64'd0, 0);
        run("DIVU after0", 3'd7, 32'd9, 32'd3, 64'd0, 0);
        run("MSUB", 3'd4, 32'd3, 32'd5, 64'h10, 0);
        chk("MSUB literal", result_o, 64'd1);
        run("MADDU wrap", 3'd3, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run("MADD", 3'd2, 32'hFFFF_FFFE, 32'd3, 64'd0, 3);

        // annul during a divide
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd6; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        repeat (5) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        chk("annul busy", 64'(busy_o), 64'd0);
        chk("annul ready", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("annul no ready", 64'(ready_o), 64'd0);
        run("MULTU after annul", 3'd1, 32'd2, 32'd3, 64'd0, 0);

        // reset in the middle of a multiply
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; opdata1_i = 32'd77; opdata2_i = 32'd99;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst ready", 64'(ready_o), 64'd0);
        chk("rst result", result_o, 64'd0);
        @(negedge clk); rst = 1'b0;

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(7, 0));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(5, 0))
                0:       rb = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(15, 1));
                default: ra = ra;
            endcase
            run("random", rop, ra, rb, {$urandom, $urandom}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
